// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- two-phase instruction fetch sequencer with halt support.
//
// Each instruction is fetched from instruction memory (FETCH, one or more
// cycles until imem_ack), then presented to the control datapath for one
// cycle (EXEC). While no instruction is executing, a harmless NOP_WORD is
// presented instead so control never writes a register or jumps by accident.
//
// Optional feature macro: FETCH_SELFLOOP_HALT_EN
//   defined   : a jump to the instruction's own address (jmp_if=1, A==pc)
//               halts the unit after the normal EXEC update.
//   undefined : no self-loop detection; a self-jump refetches forever.
//
// Ports
//   clk         in   1   sole clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   imem_req    out  1   fetch request to instruction memory
//   imem_addr   out  16  fetch address (the PC)
//   imem_ack    in   1   imem_rdata valid this cycle
//   imem_rdata  in   16  fetched instruction word
//   inst        out  16  instruction to control (NOP_WORD outside EXEC)
//   inst_valid  out  1   inst is real and executes this cycle
//   jmp_if      in   1   jump condition, sampled in EXEC only
//   A           in   16  jump target, sampled in EXEC only
//   halt_req    in   1   stop after the current instruction
//   resume      in   1   leave HALTED
//   halted      out  1   high in HALTED
//   retired     out  16  executed-instruction count (wraps)
//   state_dbg   out  2   current FSM state (0=FETCH, 1=EXEC, 2=HALTED)
//
// Handshake: a fetch is outstanding whenever imem_req=1; it completes on the
// first rising edge where imem_ack=1. imem_ack while imem_req=0 is ignored.
// ---------------------------------------------------------------------------
package fetch_unit_pkg;
    typedef logic [15:0] inst_word_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_EXEC   = 2'd1,
        ST_HALTED = 2'd2
    } state_t;
endpackage

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [15:0] NOP_WORD     = 16'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output inst_word_t  inst,
    output logic        inst_valid,
    input  logic        jmp_if,
    input  logic [15:0] A,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic [15:0] retired,
    output logic [1:0]  state_dbg
);

    state_t      state_q,   state_d;
    logic [15:0] pc_q,      pc_d;
    inst_word_t  ir_q,      ir_d;
    logic [15:0] retired_q, retired_d;

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_VECTOR;
            ir_q      <= NOP_WORD;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        case (state_q)
            ST_FETCH: begin
                // imem_req is always high here once out of reset, so any ack
                // seen by this process belongs to the current request.
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                pc_d      = jmp_if ? A : pc_q + 16'd1;
                retired_d = retired_q + 16'd1;
                state_d   = halt_req ? ST_HALTED : ST_FETCH;
`ifdef FETCH_SELFLOOP_HALT_EN
                // Jump-to-self can never make progress; park the core.
                if (jmp_if && (A == pc_q)) begin
                    state_d = ST_HALTED;
                end
`endif
            end
            ST_HALTED: begin
                // resume has priority over a simultaneous halt_req.
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs
    always_comb begin
        // Gating with rst_n keeps the request low for the whole reset and
        // raises it in the very first cycle after release.
        imem_req   = (state_q == ST_FETCH) && rst_n;
        imem_addr  = pc_q;
        inst       = (state_q == ST_EXEC) ? ir_q : NOP_WORD;
        inst_valid = (state_q == ST_EXEC);
        halted     = (state_q == ST_HALTED);
        retired    = retired_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Inputs are driven 1 time unit after each rising edge; outputs are checked
// at the same point, well away from the next active edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [15:0] inst;
    logic        inst_valid;
    logic        jmp_if;
    logic [15:0] a_in;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [15:0] retired;
    logic [1:0]  state_dbg;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam logic [15:0] NOP = 16'h8000;

    fetch_unit #(
        .RESET_VECTOR(16'h0000),
        .NOP_WORD    (16'h8000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .inst_valid(inst_valid),
        .jmp_if    (jmp_if),
        .A         (a_in),
        .halt_req  (halt_req),
        .resume    (resume),
        .halted    (halted),
        .retired   (retired),
        .state_dbg (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    // Checks of a FETCH cycle at a given address
    task automatic check_fetch(input string tag, input logic [15:0] addr);
        check({tag, "_req"},   {15'd0, imem_req},   16'd1);
        check({tag, "_addr"},  imem_addr,           addr);
        check({tag, "_inst"},  inst,                NOP);
        check({tag, "_valid"}, {15'd0, inst_valid}, 16'd0);
    endtask

    // Checks of an EXEC cycle presenting a given word
    task automatic check_exec(input string tag, input logic [15:0] word);
        check({tag, "_req"},   {15'd0, imem_req},   16'd0);
        check({tag, "_inst"},  inst,                word);
        check({tag, "_valid"}, {15'd0, inst_valid}, 16'd1);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 16'h8000;
        jmp_if     = 1'b0;
        a_in       = 16'h0000;
        halt_req   = 1'b0;
        resume     = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_req",     {15'd0, imem_req},   16'd0);
        check("rst_addr",    imem_addr,           16'h0000);
        check("rst_inst",    inst,                NOP);
        check("rst_valid",   {15'd0, inst_valid}, 16'd0);
        check("rst_halted",  {15'd0, halted},     16'd0);
        check("rst_retired", retired,             16'd0);

        // Release: request in the very first cycle, zero-wait memory.
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        #1;
        // ---------------- zero-wait stream 0,1,2,3 ----------------
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) check_fetch("zw_fetch", 16'(i / 2));
            else            check_exec("zw_exec", NOP);
            step();
        end
        check("zw_retired4", retired, 16'd4);

        // ---------------- wait states at address 5 ----------------
        check_fetch("pre5_fetch", 16'd4);
        step();                       // EXEC at 4
        imem_ack = 1'b0;
        step();                       // FETCH at 5
        for (int j = 0; j < 4; j++) begin
            check_fetch("wait5", 16'd5);
            if (j == 3) begin
                imem_ack   = 1'b1;
                imem_rdata = 16'h1234;
            end
            step();
        end
        check_exec("wait5_exec", 16'h1234);
        check("wait5_retired", retired, 16'd5);

        // ---------------- jumps around pc=10 ----------------
        jmp_if     = 1'b1;
        a_in       = 16'd10;
        imem_rdata = 16'hABCD;
        step();
        check_fetch("to10", 16'd10);
        step();
        check_exec("exec10", 16'hABCD);
        a_in = 16'h0040;
        step();
        check_fetch("jmp40", 16'h0040);
        step();                       // EXEC at 0x40
        a_in = 16'd10;
        step();                       // FETCH at 10
        step();                       // EXEC at 10
        jmp_if = 1'b0;
        step();
        check_fetch("nojmp11", 16'd11);
        check("ret9", retired, 16'd9);

        // ---------------- pc wrap at 16'hFFFF ----------------
        step();                       // EXEC at 11
        jmp_if = 1'b1;
        a_in   = 16'hFFFF;
        step();
        check_fetch("atFFFF", 16'hFFFF);
        step();                       // EXEC at FFFF
        jmp_if = 1'b0;
        step();
        check_fetch("wrap0", 16'h0000);
        check("wrap_ret", retired, 16'd11);

        // ---------------- halt at pc=7, resume at 8 ----------------
        step();                       // EXEC at 0
        jmp_if = 1'b1;
        a_in   = 16'd7;
        step();
        check_fetch("at7", 16'd7);
        step();                       // EXEC at 7
        jmp_if   = 1'b0;
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("halt_halted", {15'd0, halted},     16'd1);
            check("halt_req0",   {15'd0, imem_req},   16'd0);
            check("halt_inst",   inst,                NOP);
            check("halt_valid",  {15'd0, inst_valid}, 16'd0);
            step();
        end
        check("halt_ret_hold", retired, 16'd13);
        // resume wins over a simultaneous halt_req
        halt_req = 1'b1;
        resume   = 1'b1;
        step();
        resume = 1'b0;
        check_fetch("resume8", 16'd8);
        check("resume_halted", {15'd0, halted}, 16'd0);
        // halt_req outside EXEC is ignored: FETCH still moves to EXEC
        step();
        check_exec("halt_ign_exec", 16'hABCD);
        halt_req = 1'b0;

        // ---------------- self-jump at pc=20 ----------------
        jmp_if = 1'b1;
        a_in   = 16'd20;
        step();
        check_fetch("at20", 16'd20);
        step();                       // EXEC at 20, jump to self
        step();
        check("self_ret", retired, 16'd15);
`ifdef FETCH_SELFLOOP_HALT_EN
        check("self_halted", {15'd0, halted},   16'd1);
        check("self_req",    {15'd0, imem_req}, 16'd0);
        check("self_pc",     imem_addr,         16'd20);
`else
        check_fetch("self_refetch1", 16'd20);
        step();
        step();
        check_fetch("self_refetch2", 16'd20);
        check("self_ret2", retired, 16'd16);
`endif

        // ---------------- reset during an outstanding fetch ----------------
        jmp_if   = 1'b0;
        imem_ack = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",     {15'd0, imem_req}, 16'd0);
        check("arst_addr",    imem_addr,         16'h0000);
        check("arst_retired", retired,           16'd0);
        check("arst_halted",  {15'd0, halted},   16'd0);
        imem_ack   = 1'b1;        // late ack arriving while in reset
        imem_rdata = 16'h5555;
        step();
        check("arst_req_hold", {15'd0, imem_req}, 16'd0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        #1;
        check_fetch("post_rst", 16'h0000);
        step();
        check_fetch("post_rst_wait", 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
